// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Holds the program counter and issues one instruction-memory request at a
// time. Fetched words go to an output slot for the IF/ID register. A one-entry
// skid buffer absorbs downstream stalls, and redirects flush the front end.
//
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, a misaligned
// redirect target raises misalign_out for one cycle and is rounded down to a
// word boundary.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   stall_in                downstream cannot accept the output slot
//   redirect_in/_pc_in      taken branch/jump and its target
//   imem_req_out/addr_out   fetch request; held stable until imem_ack_in
//   imem_ack_in/rdata_in    completion of the outstanding request
//   inst_out, pc_out,       output slot (registered)
//   pc_plus4_out,
//   inst_valid_out
//   misalign_out            misaligned redirect pulse (PC_ALIGN_CHECK_EN only)
module pc_fetch_unit #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = '0,
    parameter int unsigned          INCR     = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             stall_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    output logic             imem_req_out,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_ack_in,
    input  logic [31:0]      imem_rdata_in,
    output logic [31:0]      inst_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4_out,
    output logic             inst_valid_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign_out
`endif
);

    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STALL = 2'd3
    } state_e;

    // One fetched instruction together with its address information.
    typedef struct packed {
        logic [31:0]      inst;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc4;
    } entry_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    entry_t           slot_q, slot_d;
    logic             slot_valid_q, slot_valid_d;
    entry_t           skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             misalign_q, misalign_d;

    logic             consume;
    logic [WIDTH-1:0] redir_pc;
    entry_t           fetched;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            req_addr_q   <= '0;
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next-state logic: redirect first, then per-state fetch/stall handling.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        misalign_d   = 1'b0;

        consume      = slot_valid_q && !stall_in;

`ifdef PC_ALIGN_CHECK_EN
        redir_pc   = {redirect_pc_in[WIDTH-1:2], 2'b00};
        misalign_d = redirect_in && (redirect_pc_in[1:0] != 2'b00);
`else
        redir_pc   = redirect_pc_in;
`endif

        // The returning word always belongs to the latched request address.
        fetched.inst = imem_rdata_in;
        fetched.pc   = req_addr_q;
        fetched.pc4  = req_addr_q + INCR_W;

        if (consume) begin
            slot_valid_d = 1'b0;
        end

        if (redirect_in) begin
            pc_d         = redir_pc;
            slot_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            // An unacked request must complete before the new address goes out.
            if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_ack_in) begin
                state_d = ST_DRAIN;
            end else begin
                state_d    = ST_FETCH;
                req_addr_d = redir_pc;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d    = ST_FETCH;
                    req_addr_d = pc_q;
                end
                ST_FETCH: begin
                    if (imem_ack_in) begin
                        pc_d = pc_q + INCR_W;
                        // Skid is always empty here, so a blocked slot fills it.
                        if (!slot_valid_q || consume) begin
                            slot_d       = fetched;
                            slot_valid_d = 1'b1;
                            req_addr_d   = pc_q + INCR_W;
                        end else begin
                            skid_d       = fetched;
                            skid_valid_d = 1'b1;
                            state_d      = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (consume) begin
                        slot_d       = skid_q;
                        slot_valid_d = skid_valid_q;
                        skid_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                        req_addr_d   = pc_q;
                    end
                end
                ST_DRAIN: begin
                    // Stale data from the pre-redirect request is dropped.
                    if (imem_ack_in) begin
                        state_d    = ST_FETCH;
                        req_addr_d = pc_q;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // Request is decoded from registered state only.
    assign imem_req_out   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr_out  = req_addr_q;
    assign inst_out       = slot_q.inst;
    assign pc_out         = slot_q.pc;
    assign pc_plus4_out   = slot_q.pc4;
    assign inst_valid_out = slot_valid_q;

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_out   = misalign_q;
`else
    // Keeps the flop connected-free builds quiet; folded away in synthesis.
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes the expected sequence of
// consumed instructions; a monitor pops one entry per consumed slot.
module tb_pc_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic [31:0] imem_rdata_in = '0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        inst_valid_out;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_out;
`endif

    pc_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .INCR     (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_ack_in    (imem_ack_in),
        .imem_rdata_in  (imem_rdata_in),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out),
        .inst_valid_out (inst_valid_out)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_out   (misalign_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mem_lat  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.pc4  = pc4;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Memory model: ack after mem_lat waiting cycles, data = {addr[23:0], 8'h13}.
    initial begin : mem_model
        int lat_cnt;
        lat_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (imem_req_out) begin
                if (lat_cnt >= mem_lat) begin
                    imem_ack_in   = 1'b1;
                    imem_rdata_in = {imem_addr_out[23:0], 8'h13};
                    lat_cnt       = 0;
                end else begin
                    imem_ack_in   = 1'b0;
                    imem_rdata_in = 32'hDEAD_BEEF;
                    lat_cnt++;
                end
            end else begin
                imem_ack_in   = 1'b0;
                imem_rdata_in = 32'hDEAD_BEEF;
                lat_cnt       = 0;
            end
        end
    end

    // Monitor: every slot taken downstream must match the next expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            #1;
            if (!rst_in && inst_valid_out && !stall_in) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected got pc=%h inst=%h", pc_out, inst_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_plus4_out !== e.pc4 || inst_out !== e.inst) begin
                        n_errors++;
                        $display("FAIL sb_slot got pc=%h pc4=%h inst=%h exp pc=%h pc4=%h inst=%h",
                                 pc_out, pc_plus4_out, inst_out, e.pc, e.pc4, e.inst);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) tick();
        chk("rst_valid",   32'(inst_valid_out), 32'd0);
        chk("rst_req",     32'(imem_req_out),   32'd0);
        chk("rst_addr",    imem_addr_out,       32'h0);
        chk("rst_pc",      pc_out,              32'h0);
        chk("rst_pc4",     pc_plus4_out,        32'h0);
        chk("rst_inst",    inst_out,            32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_misalign", 32'(misalign_out),  32'd0);
`endif

        // Run 1: zero-wait streaming, stall, redirect+ack+stall to wrap address.
        push(32'h0000_0000, 32'h0000_0004, 32'h0000_0013);
        push(32'h0000_0004, 32'h0000_0008, 32'h0000_0413);
        push(32'h0000_0008, 32'h0000_000C, 32'h0000_0813);
        push(32'h0000_000C, 32'h0000_0010, 32'h0000_0C13);
        push(32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FC13);
        push(32'h0000_0000, 32'h0000_0004, 32'h0000_0013);
        mem_lat = 0;
        rst_in  = 1'b0;                                   // cycle 0
        chk("boot_req", 32'(imem_req_out), 32'd0);
        tick();                                           // cycle 1
        chk("c1_req",  32'(imem_req_out), 32'd1);
        chk("c1_addr", imem_addr_out,     32'h0);
        tick();                                           // cycle 2
        chk("c2_addr",  imem_addr_out,       32'h4);
        chk("c2_valid", 32'(inst_valid_out), 32'd1);
        tick();                                           // cycle 3
        chk("c3_addr",  imem_addr_out, 32'h8);
        tick();                                           // cycle 4
        stall_in = 1'b1;
        tick();                                           // cycle 5
        chk("stall_req5", 32'(imem_req_out), 32'd0);
        tick();                                           // cycle 6
        chk("stall_req6", 32'(imem_req_out), 32'd0);
        tick();                                           // cycle 7
        stall_in = 1'b0;
        tick();                                           // cycle 8
        chk("resume_req",  32'(imem_req_out), 32'd1);
        chk("resume_addr", imem_addr_out,     32'h10);
        tick();                                           // cycle 9
        stall_in       = 1'b1;
        redirect_in    = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFC;
        tick();                                           // cycle 10
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        chk("redir_flush", 32'(inst_valid_out), 32'd0);
        chk("redir_addr",  imem_addr_out,       32'hFFFF_FFFC);
        tick();                                           // cycle 11
        chk("wrap_addr", imem_addr_out, 32'h0);
        chk("wrap_pc4",  pc_plus4_out,  32'h0);
        tick();                                           // cycle 12
        tick();                                           // cycle 13
        chk("pre_rst_req", 32'(imem_req_out), 32'd1);
        rst_in   = 1'b1;
        stall_in = 1'b1;
        tick();
        chk("mid_rst_req",   32'(imem_req_out),   32'd0);
        chk("mid_rst_valid", 32'(inst_valid_out), 32'd0);
        mem_lat = 2;
        tick();

        // Run 2: 3-cycle memory, redirect while a request to 0x8 is pending.
        push(32'h0000_0000, 32'h0000_0004, 32'h0000_0013);
        push(32'h0000_0004, 32'h0000_0008, 32'h0000_0413);
        push(32'h0000_0100, 32'h0000_0104, 32'h0001_0013);
        rst_in   = 1'b0;                                  // cycle 0'
        stall_in = 1'b0;
        tick();                                           // cycle 1'
        chk("r2_addr0", imem_addr_out, 32'h0);
        repeat (7) tick();                                // cycle 8'
        chk("r2_empty", 32'(inst_valid_out), 32'd0);
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0100;
        tick();                                           // cycle 9'
        redirect_in = 1'b0;
        chk("drain_req",  32'(imem_req_out), 32'd1);
        chk("drain_addr", imem_addr_out,     32'h8);
        tick();                                           // cycle 10'
        chk("post_drain_addr",  imem_addr_out,       32'h100);
        chk("post_drain_valid", 32'(inst_valid_out), 32'd0);
        repeat (3) tick();                                // cycle 13'
        chk("r2_pc", pc_out, 32'h100);
        tick();                                           // cycle 14'
        stall_in = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0102;
        tick();                                           // cycle 15'
        redirect_in = 1'b0;
        chk("misalign_pulse", 32'(misalign_out), 32'd1);
        tick();                                           // cycle 16'
        chk("misalign_clear", 32'(misalign_out), 32'd0);
        chk("aligned_addr",   imem_addr_out,     32'h100);
`endif
        repeat (3) tick();
        #2;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
